rs_single_err_locator: RTL and testbench

Single-error locator for the Reed-Solomon decoders (C1/C2) over GF(256), primitive polynomial 0x11D, alpha = 0x02. It takes a codeword's first two syndromes S0 and S1 and classifies the codeword as no error, one correctable error, or uncorrectable. For a single error it returns the error position and value. It sits between the syndrome stage and the erasure/correction stage, drives the shared `gf256_inv` through its start/ready handshake, and consumes the inverse.

---
 rtl/rs_single_err_locator.sv | 155 +++++++++++++++
 tb/tb_rs_single_err_locator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_single_err_locator.sv
// Single-error locator for the RS decoders over GF(256) (poly 0x11D, alpha = 0x02).
// Classifies a codeword from S0/S1 and, for one error, searches alpha^j == S1/S0.
module rs_single_err_locator #(
   parameter int unsigned N = 32
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [7:0] i_s0,
   input  logic [7:0] i_s1,
   output logic       o_inv_start,
   output logic [7:0] o_inv_x,
   input  logic [7:0] i_inv_y,
   input  logic       i_inv_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_status,
   output logic [7:0] o_err_pos,
   output logic [7:0] o_err_val
);

   localparam logic [1:0] StatNone   = 2'b00;
   localparam logic [1:0] StatSingle = 2'b01;
   localparam logic [1:0] StatUncorr = 2'b10;
   localparam logic [7:0] JLast      = 8'(N - 1);

   typedef enum logic [1:0] {StIdle, StInv, StWait, StSearch} state_e;

   state_e     state_q, state_d;
   logic [7:0] s0_q, s0_d;
   logic [7:0] s1_q, s1_d;
   logic [7:0] tgt_q, tgt_d;
   logic [7:0] p_q, p_d;
   logic [7:0] j_q, j_d;
   logic       done_q, done_d;
   logic [1:0] status_q, status_d;
   logic [7:0] pos_q, pos_d;
   logic [7:0] val_q, val_d;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
   endfunction

   // Horner-style multiply, MSB of b first
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         acc = xtime(acc) ^ (b[i] ? a : 8'h00);
      end
      return acc;
   endfunction

   always_comb begin
      state_d  = state_q;
      s0_d     = s0_q;
      s1_d     = s1_q;
      tgt_d    = tgt_q;
      p_d      = p_q;
      j_d      = j_q;
      done_d   = 1'b0;
      status_d = status_q;
      pos_d    = pos_q;
      val_d    = val_q;
      case (state_q)
         StIdle: begin
            if (i_start) begin
               s0_d = i_s0;
               s1_d = i_s1;
               if (i_s0 == 8'h00 && i_s1 == 8'h00) begin
                  done_d   = 1'b1;
                  status_d = StatNone;
                  pos_d    = 8'h00;
                  val_d    = 8'h00;
               end else if (i_s0 == 8'h00 || i_s1 == 8'h00) begin
                  done_d   = 1'b1;
                  status_d = StatUncorr;
                  pos_d    = 8'h00;
                  val_d    = 8'h00;
               end else begin
                  state_d = StInv;
               end
            end
         end
         StInv: begin
            state_d = StWait;
         end
         StWait: begin
            // Ready is only trusted from WAIT on; a stale high was cleared by the INV load
            if (i_inv_ready) begin
               tgt_d   = gf_mul(s1_q, i_inv_y);
               p_d     = 8'h01;
               j_d     = 8'h00;
               state_d = StSearch;
            end
         end
         StSearch: begin
            if (p_q == tgt_q) begin
               done_d   = 1'b1;
               status_d = StatSingle;
               pos_d    = j_q;
               val_d    = s0_q;
               state_d  = StIdle;
            end else if (j_q == JLast) begin
               done_d   = 1'b1;
               status_d = StatUncorr;
               pos_d    = 8'h00;
               val_d    = 8'h00;
               state_d  = StIdle;
            end else begin
               p_d = xtime(p_q);
               j_d = j_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         s0_q     <= 8'h00;
         s1_q     <= 8'h00;
         tgt_q    <= 8'h00;
         p_q      <= 8'h00;
         j_q      <= 8'h00;
         done_q   <= 1'b0;
         status_q <= 2'b00;
         pos_q    <= 8'h00;
         val_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         s0_q     <= s0_d;
         s1_q     <= s1_d;
         tgt_q    <= tgt_d;
         p_q      <= p_d;
         j_q      <= j_d;
         done_q   <= done_d;
         status_q <= status_d;
         pos_q    <= pos_d;
         val_q    <= val_d;
      end
   end

   assign o_inv_start = (state_q == StInv);
   assign o_inv_x     = s0_q;
   assign o_busy      = (state_q != StIdle);
   assign o_done      = done_q;
   assign o_status    = status_q;
   assign o_err_pos   = pos_q;
   assign o_err_val   = val_q;

endmodule

// File: tb/tb_rs_single_err_locator.sv
// Directed bench for rs_single_err_locator with a behavioural 8-cycle GF(256) inverter
// and a queue scoreboard of expected results.
module tb_rs_single_err_locator;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_start;
   logic [7:0] i_s0;
   logic [7:0] i_s1;
   logic       o_inv_start;
   logic [7:0] o_inv_x;
   logic [7:0] i_inv_y;
   logic       i_inv_ready;
   logic       o_busy;
   logic       o_done;
   logic [1:0] o_status;
   logic [7:0] o_err_pos;
   logic [7:0] o_err_val;

   typedef struct {
      logic [1:0] st;
      logic [7:0] pos;
      logic [7:0] val;
      int         edge_n;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;
   int   inv_cnt;
   int   stall;

   rs_single_err_locator #(.N(32)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_s0        (i_s0),
      .i_s1        (i_s1),
      .o_inv_start (o_inv_start),
      .o_inv_x     (o_inv_x),
      .i_inv_y     (i_inv_y),
      .i_inv_ready (i_inv_ready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_status    (o_status),
      .o_err_pos   (o_err_pos),
      .o_err_val   (o_err_val)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // LSB-first shift-and-add multiply
   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, aa, bb;
      r  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) r = r ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
         bb = bb >> 1;
      end
      return r;
   endfunction

   function automatic logic [7:0] tb_inv(input logic [7:0] x);
      for (int y = 1; y < 256; y++) begin
         if (tb_mul(x, 8'(y)) == 8'h01) return 8'(y);
      end
      return 8'h00;
   endfunction

   // Inverter model: loads on start, ready rises 7 edges later (plus optional stall).
   // Not reset by i_rst_n so stale ready/result survive a locator reset.
   initial begin
      i_inv_ready = 1'b1;
      i_inv_y     = 8'h00;
      inv_cnt     = 0;
      stall       = 0;
   end
   always @(posedge i_clk) begin
      if (o_inv_start) begin
         inv_cnt     <= 7 + stall;
         i_inv_ready <= 1'b0;
         i_inv_y     <= tb_inv(o_inv_x);
      end else if (inv_cnt != 0) begin
         inv_cnt <= inv_cnt - 1;
         if (inv_cnt == 1) i_inv_ready <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request; inj_at >= 0 pulses a foreign start at that sample index.
   task automatic run_req(input logic [7:0] s0, input logic [7:0] s1, input logic [1:0] st,
                          input logic [7:0] pos, input logic [7:0] val, input int edge_n,
                          input int inj_at);
      int   k;
      exp_t e;
      exp_q.push_back('{st: st, pos: pos, val: val, edge_n: edge_n});
      i_s0    = s0;
      i_s1    = s1;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      k = 0;
      if (edge_n == 0) begin
         check("inv_start_trivial", 32'(o_inv_start), 32'd0);
         check("busy_trivial", 32'(o_busy), 32'd0);
      end else begin
         check("inv_start_in_inv", 32'(o_inv_start), 32'd1);
         check("inv_x", 32'(o_inv_x), 32'(s0));
         check("busy_after_accept", 32'(o_busy), 32'd1);
      end
      while (!o_done && k < 300) begin
         if (k == inj_at) begin
            i_start = 1'b1;
            i_s0    = 8'h01;
            i_s1    = 8'h02;
         end else begin
            i_start = 1'b0;
         end
         @(posedge i_clk);
         #1;
         k++;
      end
      i_start = 1'b0;
      if (!o_done) begin
         checks++;
         failures++;
         $error("FAIL done_timeout observed=no_done expected=done_at_edge_%0d", edge_n);
         void'(exp_q.pop_front());
         i_rst_n = 1'b0;
         #2;
         i_rst_n = 1'b1;
         return;
      end
      e = exp_q.pop_front();
      check("status", 32'(o_status), 32'(e.st));
      check("err_pos", 32'(o_err_pos), 32'(e.pos));
      check("err_val", 32'(o_err_val), 32'(e.val));
      check("done_edge", 32'(k), 32'(e.edge_n));
      check("busy_in_done", 32'(o_busy), 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      i_rst_n  = 1'b0;
      i_start  = 1'b0;
      i_s0     = 8'h00;
      i_s1     = 8'h00;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_status", 32'(o_status), 32'd0);
      check("rst_inv_start", 32'(o_inv_start), 32'd0);
      check("rst_inv_x", 32'(o_inv_x), 32'd0);
      i_rst_n = 1'b1;
      idle(1);

      run_req(8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 0, -1);
      idle(2);
      run_req(8'h05, 8'h05, 2'b01, 8'h00, 8'h05, 10, -1);
      idle(1);
      run_req(8'h01, 8'h08, 2'b01, 8'h03, 8'h01, 13, -1);
      idle(3);
      run_req(8'h00, 8'h07, 2'b10, 8'h00, 8'h00, 0, -1);
      idle(1);
      check("hold_status", 32'(o_status), 32'd2);
      run_req(8'h01, 8'h9D, 2'b10, 8'h00, 8'h00, 41, -1);
      idle(2);
      run_req(8'h01, 8'h1D, 2'b01, 8'h08, 8'h01, 18, -1);
      idle(2);

      // Start during SEARCH must be ignored
      run_req(8'h07, 8'h0E, 2'b01, 8'h01, 8'h07, 11, 10);
      idle(2);
      check("hold_pos", 32'(o_err_pos), 32'd1);

      // Back-to-back: next request in the o_done cycle
      run_req(8'h01, 8'h08, 2'b01, 8'h03, 8'h01, 13, -1);
      run_req(8'h33, 8'h00, 2'b10, 8'h00, 8'h00, 0, -1);
      run_req(8'h02, 8'h3A, 2'b01, 8'h08, 8'h02, 18, -1);

      // Stalled inverter extends WAIT
      stall = 5;
      run_req(8'h10, 8'h40, 2'b01, 8'h02, 8'h10, 17, -1);
      stall = 0;
      idle(1);

      // Reset during WAIT, then a clean request with stale inverter state
      i_s0    = 8'h05;
      i_s1    = 8'h07;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      idle(3);
      check("pre_rst_busy", 32'(o_busy), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_done", 32'(o_done), 32'd0);
      check("mid_rst_inv_start", 32'(o_inv_start), 32'd0);
      check("mid_rst_status", 32'(o_status), 32'd0);
      check("mid_rst_pos", 32'(o_err_pos), 32'd0);
      check("mid_rst_val", 32'(o_err_val), 32'd0);
      check("mid_rst_inv_x", 32'(o_inv_x), 32'd0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      idle(1);
      run_req(8'h01, 8'h02, 2'b01, 8'h01, 8'h01, 11, -1);
      idle(2);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
